// File: rtl/windower_pad_stride.sv
// Sliding-window extractor with zero padding on both image edges and stride decimation.
// Define WINDOWER_IDX_OUT_EN to add the win_idx output (index of each emitted window).
module windower_pad_stride #(
  parameter int WINDOW_SIZE   = 3,
  parameter int NO_CH         = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int STRIDE        = 1,
  parameter int PAD           = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                vld_in,
  output logic                                rdy_out,
  input  logic [NO_CH-1:0]                    data_in,
  output logic                                vld_out,
  output logic [WINDOW_SIZE-1:0][NO_CH-1:0]   data_out
`ifdef WINDOWER_IDX_OUT_EN
  ,
  output logic [LOG2_IMG_SIZE:0]              win_idx
`endif
);

  localparam int N  = 1 << LOG2_IMG_SIZE;
  localparam int CW = LOG2_IMG_SIZE + 2;
  localparam int NW = LOG2_IMG_SIZE + 1;
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] C_FIRST       = CW'(PAD + 1);
  localparam logic [CW-1:0] C_FLUSH_LAST  = CW'(N + 2 * PAD - 1);
  localparam logic [CW-1:0] C_WIN         = CW'(WINDOW_SIZE);
  localparam logic [NW-1:0] CNT_LAST      = NW'(N - 1);
  localparam logic [SW-1:0] STRIDE_RELOAD = SW'(STRIDE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam state_t END_STATE = (PAD > 0) ? FLUSH : DONE;

  state_t                            state_r;
  logic [WINDOW_SIZE-1:0][NO_CH-1:0] win_r;
  logic [WINDOW_SIZE-1:0][NO_CH-1:0] win_next_s;
  logic [CW-1:0]                     c_r;
  logic [CW-1:0]                     c_next_s;
  logic [NW-1:0]                     cnt_r;
  logic [SW-1:0]                     stride_r;
  logic                              accept_s;
  logic                              last_s;
  logic                              shift_s;
  logic                              full_s;
  logic                              emit_s;
  logic [NO_CH-1:0]                  shin_s;
`ifdef WINDOWER_IDX_OUT_EN
  logic [LOG2_IMG_SIZE:0]            idx_r;
`endif

  // Next window, shift count and emit decision for the current cycle.
  always_comb begin
    accept_s = vld_in & rdy_out;
    last_s   = (cnt_r == CNT_LAST);
    shift_s  = 1'b0;
    shin_s   = {NO_CH{1'b0}};
    case (state_r)
      IDLE, RUN: begin
        shift_s = accept_s;
        shin_s  = data_in;
      end
      FLUSH:   shift_s = 1'b1;
      DONE:    shift_s = 1'b0;
      default: shift_s = 1'b0;
    endcase
    // Starting an image clears the window, which supplies the leading pad zeros.
    if (state_r == IDLE) begin
      c_next_s = C_FIRST;
    end else begin
      c_next_s = c_r + CW'(1);
    end
    win_next_s[0] = shin_s;
    for (int i = 1; i < WINDOW_SIZE; i++) begin
      if (state_r == IDLE) begin
        win_next_s[i] = {NO_CH{1'b0}};
      end else begin
        win_next_s[i] = win_r[i-1];
      end
    end
    full_s = (c_next_s >= C_WIN);
    emit_s = shift_s & full_s & (stride_r == SW'(0));
  end

  // Control FSM, window/counter state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      rdy_out  <= 1'b1;
      vld_out  <= 1'b0;
      data_out <= '0;
      win_r    <= '0;
      c_r      <= '0;
      cnt_r    <= '0;
      stride_r <= '0;
`ifdef WINDOWER_IDX_OUT_EN
      idx_r    <= '0;
      win_idx  <= '0;
`endif
    end else begin
      vld_out <= emit_s;
      if (emit_s) begin
        data_out <= win_next_s;
      end
      if (shift_s) begin
        win_r <= win_next_s;
        c_r   <= c_next_s;
        // Stride counter ticks once per complete window and emits when it reads zero.
        if (full_s) begin
          stride_r <= (stride_r == SW'(0)) ? STRIDE_RELOAD : stride_r - SW'(1);
        end
      end
`ifdef WINDOWER_IDX_OUT_EN
      if (emit_s) begin
        win_idx <= idx_r;
        idx_r   <= idx_r + NW'(1);
      end
`endif
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r   <= NW'(1);
            state_r <= last_s ? END_STATE : RUN;
            rdy_out <= ~last_s;
          end
        end
        RUN: begin
          if (accept_s) begin
            cnt_r <= cnt_r + NW'(1);
            if (last_s) begin
              state_r <= END_STATE;
              rdy_out <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (c_r == C_FLUSH_LAST) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          c_r      <= '0;
          cnt_r    <= '0;
          stride_r <= '0;
`ifdef WINDOWER_IDX_OUT_EN
          idx_r    <= '0;
`endif
          state_r  <= IDLE;
          rdy_out  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          rdy_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_windower_pad_stride.sv
// Bench for windower_pad_stride: three configurations (W/P/S = 3/1/1, 3/1/2, 2/0/1), N = 8,
// checked against a padded-sequence reference model.
module tb_windower_pad_stride;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             vld  [3];
  logic [3:0]       din  [3];
  logic             rdy  [3];
  logic             vout [3];
  logic [2:0][3:0]  dout0;
  logic [2:0][3:0]  dout1;
  logic [1:0][3:0]  dout2;
`ifdef WINDOWER_IDX_OUT_EN
  logic [3:0]       widx0, widx1, widx2;
`endif

  int cfg_w [3] = '{3, 3, 2};
  int cfg_p [3] = '{1, 1, 0};
  int cfg_s [3] = '{1, 2, 1};

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] got0 [$];
  logic [11:0] got1 [$];
  logic [11:0] got2 [$];
  int          gidx0 [$];

  windower_pad_stride #(.WINDOW_SIZE(3), .NO_CH(4), .LOG2_IMG_SIZE(3), .STRIDE(1), .PAD(1)) dut0 (
    .clk(clk), .rst(rst), .vld_in(vld[0]), .rdy_out(rdy[0]), .data_in(din[0]),
    .vld_out(vout[0]), .data_out(dout0)
`ifdef WINDOWER_IDX_OUT_EN
    , .win_idx(widx0)
`endif
  );
  windower_pad_stride #(.WINDOW_SIZE(3), .NO_CH(4), .LOG2_IMG_SIZE(3), .STRIDE(2), .PAD(1)) dut1 (
    .clk(clk), .rst(rst), .vld_in(vld[1]), .rdy_out(rdy[1]), .data_in(din[1]),
    .vld_out(vout[1]), .data_out(dout1)
`ifdef WINDOWER_IDX_OUT_EN
    , .win_idx(widx1)
`endif
  );
  windower_pad_stride #(.WINDOW_SIZE(2), .NO_CH(4), .LOG2_IMG_SIZE(3), .STRIDE(1), .PAD(0)) dut2 (
    .clk(clk), .rst(rst), .vld_in(vld[2]), .rdy_out(rdy[2]), .data_in(din[2]),
    .vld_out(vout[2]), .data_out(dout2)
`ifdef WINDOWER_IDX_OUT_EN
    , .win_idx(widx2)
`endif
  );

  // Capture every emitted window on the falling edge.
  always @(negedge clk) begin
    if (vout[0]) begin
      got0.push_back(dout0);
`ifdef WINDOWER_IDX_OUT_EN
      gidx0.push_back(int'(widx0));
`endif
    end
    if (vout[1]) got1.push_back(dout1);
    if (vout[2]) got2.push_back({4'h0, dout2});
  end

  // Windows k = 0, S, 2S, ... over the zero-padded image; nibble i holds padded index k+W-1-i.
  function automatic void model(input int w, input int p, input int s,
                                input logic [3:0] smp [$], output logic [11:0] q [$]);
    int l;
    int j;
    logic [11:0] win;
    l = 8 + 2 * p;
    q = {};
    for (int k = 0; k <= l - w; k += s) begin
      win = 12'h000;
      for (int i = 0; i < w; i++) begin
        j = k + w - 1 - i;
        if (j >= p && j < p + 8) win[i*4 +: 4] = smp[j-p];
      end
      q.push_back(win);
    end
  endfunction

  function automatic void fetch(input int d, output logic [11:0] q [$]);
    case (d)
      0:       q = got0;
      1:       q = got1;
      default: q = got2;
    endcase
  endfunction

  task automatic clear_got();
    got0.delete();
    got1.delete();
    got2.delete();
    gidx0.delete();
  endtask

  function automatic void rand_image(output logic [3:0] s [$], input int n);
    s = {};
    for (int i = 0; i < n; i++) s.push_back(4'($urandom));
  endfunction

  // mode 0: vld held high; 1: pattern 1,0,0; 2: random. Returns loop cycles and rdy-low cycles after.
  task automatic drive(input int d, input logic [3:0] s [$], input int mode,
                       output int cycles, output int low);
    int i = 0;
    bit gap_prev = 1'b0;
    cycles = 0;
    low = 0;
    while (i < s.size() && cycles < 400) begin
      @(negedge clk);
      if (gap_prev) begin
        n_cmp++;
        if (vout[d] !== 1'b0) begin
          n_err++;
          $display("FAIL gap_vld dut%0d: vld_out=%b after idle cycle, want 0", d, vout[d]);
        end
      end
      case (mode)
        0:       vld[d] = 1'b1;
        1:       vld[d] = (cycles % 3 == 0);
        default: vld[d] = 1'($urandom_range(0, 1));
      endcase
      din[d]   = vld[d] ? s[i] : 4'($urandom);
      gap_prev = !vld[d] && rdy[d];
      if (vld[d] && rdy[d]) i++;
      cycles++;
    end
    @(negedge clk);
    vld[d] = 1'b0;
    n_cmp++;
    if (i != s.size()) begin
      n_err++;
      $display("FAIL drive_timeout dut%0d: accepted %0d samples, want %0d", d, i, s.size());
    end
    while (rdy[d] === 1'b0 && low < 10) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [11:0] cur;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0;
      din[d] = 4'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cur = (d == 0) ? dout0 : (d == 1) ? dout1 : {4'h0, dout2};
      n_cmp += 3;
      if (vout[d] !== 1'b0) begin n_err++; $display("FAIL reset_vld dut%0d: %b want 0", d, vout[d]); end
      if (rdy[d] !== 1'b1)  begin n_err++; $display("FAIL reset_rdy dut%0d: %b want 1", d, rdy[d]); end
      if (cur !== 12'h000)  begin n_err++; $display("FAIL reset_data dut%0d: %h want 000", d, cur); end
    end
  endtask

  task automatic test_directed();
    logic [3:0]  s [$];
    logic [11:0] exp [$];
    logic [11:0] got [$];
    int c0, c1, c2, l0, l1, l2;
    s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    clear_got();
    fork
      drive(0, s, 0, c0, l0);
      drive(1, s, 0, c1, l1);
      drive(2, s, 0, c2, l2);
    join
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      model(cfg_w[d], cfg_p[d], cfg_s[d], s, exp);
      fetch(d, got);
      n_cmp++;
      if (got.size() != exp.size()) begin
        n_err++;
        $display("FAIL directed_count dut%0d: %0d windows, want %0d", d, got.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (got[i] !== exp[i]) begin
          n_err++;
          $display("FAIL directed_win dut%0d[%0d]: %h want %h", d, i, got[i], exp[i]);
        end
      end
    end
    n_cmp += 8;
    if (got0.size() != 8)    begin n_err++; $display("FAIL w3s1_count: %0d want 8", got0.size()); end
    if (got0[0] !== 12'h012) begin n_err++; $display("FAIL w3s1_first: %h want 012", got0[0]); end
    if (got0[7] !== 12'h780) begin n_err++; $display("FAIL w3s1_last: %h want 780", got0[7]); end
    if (got1[3] !== 12'h678) begin n_err++; $display("FAIL w3s2_last: %h want 678", got1[3]); end
    if (got2[0] !== 12'h012) begin n_err++; $display("FAIL w2p0_first: %h want 012", got2[0]); end
    if (got2[6] !== 12'h078) begin n_err++; $display("FAIL w2p0_last: %h want 078", got2[6]); end
    if (l0 != 2)             begin n_err++; $display("FAIL rdy_low_p1: %0d cycles want 2", l0); end
    if (l2 != 1)             begin n_err++; $display("FAIL rdy_low_p0: %0d cycles want 1", l2); end
  endtask

  task automatic test_gaps();
    logic [3:0]  s [$];
    logic [11:0] exp [$];
    int c, l;
    rand_image(s, 8);
    clear_got();
    drive(0, s, 1, c, l);
    repeat (3) @(negedge clk);
    model(3, 1, 1, s, exp);
    n_cmp++;
    if (got0.size() != exp.size()) begin
      n_err++;
      $display("FAIL gaps_count: %0d windows, want %0d", got0.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (got0[i] !== exp[i]) begin n_err++; $display("FAIL gaps_win[%0d]: %h want %h", i, got0[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    logic [3:0]  s0 [$], s1 [$], s2 [$], sd [$];
    logic [11:0] exp [$];
    logic [11:0] got [$];
    int c0, c1, c2, l0, l1, l2;
    for (int r = 0; r < 3; r++) begin
      rand_image(s0, 8);
      rand_image(s1, 8);
      rand_image(s2, 8);
      clear_got();
      fork
        drive(0, s0, 2, c0, l0);
        drive(1, s1, 2, c1, l1);
        drive(2, s2, 1, c2, l2);
      join
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        sd = (d == 0) ? s0 : (d == 1) ? s1 : s2;
        model(cfg_w[d], cfg_p[d], cfg_s[d], sd, exp);
        fetch(d, got);
        n_cmp++;
        if (got.size() != exp.size()) begin
          n_err++;
          $display("FAIL random_count r%0d dut%0d: %0d want %0d", r, d, got.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
          n_cmp++;
          if (got[i] !== exp[i]) begin
            n_err++;
            $display("FAIL random_win r%0d dut%0d[%0d]: %h want %h", r, d, i, got[i], exp[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  part [$];
    logic [3:0]  s [$];
    logic [11:0] exp [$];
    int c, l;
    rand_image(part, 4);
    drive(0, part, 0, c, l);
    rst    = 1'b1;
    vld[0] = 1'b1;
    din[0] = 4'hf;
    @(negedge clk);
    rst    = 1'b0;
    vld[0] = 1'b0;
    clear_got();
    n_cmp += 2;
    if (vout[0] !== 1'b0) begin n_err++; $display("FAIL midrst_vld: %b want 0", vout[0]); end
    if (rdy[0] !== 1'b1)  begin n_err++; $display("FAIL midrst_rdy: %b want 1", rdy[0]); end
    s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    drive(0, s, 0, c, l);
    repeat (3) @(negedge clk);
    model(3, 1, 1, s, exp);
    n_cmp++;
    if (got0.size() != 8) begin n_err++; $display("FAIL midrst_count: %0d windows want 8", got0.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (got0[i] !== exp[i]) begin n_err++; $display("FAIL midrst_win[%0d]: %h want %h", i, got0[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  s [$], a [$], b [$];
    logic [11:0] ea [$], eb [$], exp [$];
    int c, l;
    rand_image(a, 8);
    rand_image(b, 8);
    s = {a, b};
    clear_got();
    drive(0, s, 0, c, l);
    repeat (3) @(negedge clk);
    model(3, 1, 1, a, ea);
    model(3, 1, 1, b, eb);
    exp = {ea, eb};
    n_cmp += 2;
    if (c != 18) begin n_err++; $display("FAIL b2b_cycles: %0d cycles for 16 samples, want 18", c); end
    if (got0.size() != 16) begin n_err++; $display("FAIL b2b_count: %0d windows want 16", got0.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (got0[i] !== exp[i]) begin n_err++; $display("FAIL b2b_win[%0d]: %h want %h", i, got0[i], exp[i]); end
    end
`ifdef WINDOWER_IDX_OUT_EN
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (gidx0[i] != i % 8) begin n_err++; $display("FAIL b2b_idx[%0d]: %0d want %0d", i, gidx0[i], i % 8); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gaps();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
